semi_auto_driver: RTL and testbench

SEMI_AUTO_DRIVER -- requirements
Module: semi_auto_driver

---
 rtl/semi_auto_pkg.sv | 39 +++
 rtl/cmd_edge.sv | 22 ++
 rtl/semi_auto_driver.sv | 173 +++++++++++++++++
 tb/tb_semi_auto_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/semi_auto_pkg.sv
// Shared encodings and default timing for the semi-auto driver.
// Counter values are cycle counts minus one, loaded when a timed state is entered.
package semi_auto_pkg;

  localparam int CNT_W = 27;

  localparam logic [1:0] SEMI_AUTO = 2'b10;

  localparam int unsigned DEF_TURN_CYCLES     = 90_000_000;
  localparam int unsigned DEF_SETTLE_CYCLES   = 20_000_000;
  localparam int unsigned DEF_MOVE_MIN_CYCLES = 50_000_000;

  // Button bit positions in the packed command vector.
  localparam int CMD_FWD   = 0;
  localparam int CMD_LEFT  = 1;
  localparam int CMD_RIGHT = 2;
  localparam int CMD_BACK  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_TURN   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_MOVE   = 3'd4
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Load value giving a state that lasts exactly 'cycles' clocks.
  function automatic logic [CNT_W-1:0] hold_load(input int unsigned cycles);
    int unsigned v;
    v = (cycles == 0) ? 0 : cycles - 1;
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cmd_edge.sv
// Rising-edge detector for the four debounced user buttons.
// History clears on reset, so a button held through reset reads as a fresh press.
module cmd_edge (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [3:0] cmd,
  output logic [3:0] pulse
);

  logic [3:0] hist;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      hist <= '0;
    end else begin
      hist <= cmd;
    end
  end

  assign pulse = cmd & ~hist;

endmodule

// File: rtl/semi_auto_driver.sv
// Semi-automatic driving controller: waits for a button, turns or moves forward,
// and resolves junctions on its own using the three wall detectors.
//
// state  | meaning
// IDLE   | mode inactive, all drives off
// WAIT   | waiting for a button edge, wait_light on
// TURN   | holding a 90-degree turn command (repeated once for a U-turn)
// SETTLE | drives off while detector data refreshes
// MOVE   | driving forward, junction detection armed after the minimum time
module semi_auto_driver
  import semi_auto_pkg::*;
#(
  parameter int unsigned TURN_CYCLES     = DEF_TURN_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned MOVE_MIN_CYCLES = DEF_MOVE_MIN_CYCLES
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [1:0] global_state,
  input  logic       front_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  input  logic       cmd_forward,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_back,
  output logic       move_forward_signal,
  output logic       turn_left_signal,
  output logic       turn_right_signal,
  output logic [2:0] state_code,
  output logic       wait_light
);

  state_e           state, state_nx;
  dir_e             dir, dir_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       turns_left, turns_nx;
  logic [3:0]       cmd_pulse;
  logic [3:0]       cmd_ok;
  logic             junction;

  cmd_edge u_cmd_edge (
    .sys_clk (sys_clk),
    .rst     (rst),
    .cmd     ({cmd_back, cmd_right, cmd_left, cmd_forward}),
    .pulse   (cmd_pulse)
  );

  // Presses toward a blocked direction are dropped before priority is applied.
  assign cmd_ok   = cmd_pulse & ~{1'b0, right_detector, left_detector, front_detector};
  assign junction = front_detector || !left_detector || !right_detector;

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    cnt_nx   = cnt;
    turns_nx = turns_left;

    case (state)
      ST_IDLE: begin
        cnt_nx   = '0;
        turns_nx = '0;
        if (global_state == SEMI_AUTO) state_nx = ST_WAIT;
      end

      ST_WAIT: begin
        if (cmd_ok[CMD_FWD]) begin
          state_nx = ST_MOVE;
          cnt_nx   = CNT_W'(MOVE_MIN_CYCLES);
        end else if (cmd_ok[CMD_LEFT]) begin
          state_nx = ST_TURN;
          dir_nx   = DIR_LEFT;
          turns_nx = 2'd1;
          cnt_nx   = hold_load(TURN_CYCLES);
        end else if (cmd_ok[CMD_RIGHT]) begin
          state_nx = ST_TURN;
          dir_nx   = DIR_RIGHT;
          turns_nx = 2'd1;
          cnt_nx   = hold_load(TURN_CYCLES);
        end else if (cmd_ok[CMD_BACK]) begin
          state_nx = ST_TURN;
          dir_nx   = DIR_LEFT;
          turns_nx = 2'd2;
          cnt_nx   = hold_load(TURN_CYCLES);
        end
      end

      ST_TURN: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (turns_left > 2'd1) begin
          turns_nx = turns_left - 1'b1;
          cnt_nx   = hold_load(TURN_CYCLES);
        end else begin
          state_nx = ST_SETTLE;
          turns_nx = '0;
          cnt_nx   = hold_load(SETTLE_CYCLES);
        end
      end

      ST_SETTLE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (!front_detector) begin
          state_nx = ST_MOVE;
          cnt_nx   = CNT_W'(MOVE_MIN_CYCLES);
        end else begin
          state_nx = ST_WAIT;
        end
      end

      ST_MOVE: begin
        // Counter at zero means the minimum forward time has elapsed.
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (junction) begin
          if (front_detector && (left_detector ^ right_detector)) begin
            state_nx = ST_TURN;
            dir_nx   = left_detector ? DIR_RIGHT : DIR_LEFT;
            turns_nx = 2'd1;
            cnt_nx   = hold_load(TURN_CYCLES);
          end else if (front_detector && left_detector && right_detector) begin
            state_nx = ST_TURN;
            dir_nx   = DIR_LEFT;
            turns_nx = 2'd2;
            cnt_nx   = hold_load(TURN_CYCLES);
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        turns_nx = '0;
      end
    endcase

    if (global_state != SEMI_AUTO) begin
      state_nx = ST_IDLE;
      dir_nx   = DIR_LEFT;
      cnt_nx   = '0;
      turns_nx = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      dir                 <= DIR_LEFT;
      cnt                 <= '0;
      turns_left          <= '0;
      move_forward_signal <= 1'b0;
      turn_left_signal    <= 1'b0;
      turn_right_signal   <= 1'b0;
      wait_light          <= 1'b0;
    end else begin
      state               <= state_nx;
      dir                 <= dir_nx;
      cnt                 <= cnt_nx;
      turns_left          <= turns_nx;
      move_forward_signal <= (state_nx == ST_MOVE);
      turn_left_signal    <= (state_nx == ST_TURN) && (dir_nx == DIR_LEFT);
      turn_right_signal   <= (state_nx == ST_TURN) && (dir_nx == DIR_RIGHT);
      wait_light          <= (state_nx == ST_WAIT);
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_semi_auto_driver.sv
// Directed bench for semi_auto_driver with short timing (TURN=4, SETTLE=3, MOVE_MIN=5).
// Vector table first, then hand-written multi-cycle sequences.
module tb_semi_auto_driver;

  localparam logic [3:0] NO = 4'b0000;
  localparam logic [3:0] MV = 4'b1000;
  localparam logic [3:0] TL = 4'b0100;
  localparam logic [3:0] TR = 4'b0010;
  localparam logic [3:0] WL = 4'b0001;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_TURN = 3'd2, S_SETTLE = 3'd3, S_MOVE = 3'd4;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [1:0] global_state;
  logic       front_detector, left_detector, right_detector;
  logic       cmd_forward, cmd_left, cmd_right, cmd_back;
  logic       move_forward_signal, turn_left_signal, turn_right_signal;
  logic [2:0] state_code;
  logic       wait_light;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  semi_auto_driver #(
    .TURN_CYCLES     (4),
    .SETTLE_CYCLES   (3),
    .MOVE_MIN_CYCLES (5)
  ) dut (
    .sys_clk             (sys_clk),
    .rst                 (rst),
    .global_state        (global_state),
    .front_detector      (front_detector),
    .left_detector       (left_detector),
    .right_detector      (right_detector),
    .cmd_forward         (cmd_forward),
    .cmd_left            (cmd_left),
    .cmd_right           (cmd_right),
    .cmd_back            (cmd_back),
    .move_forward_signal (move_forward_signal),
    .turn_left_signal    (turn_left_signal),
    .turn_right_signal   (turn_right_signal),
    .state_code          (state_code),
    .wait_light          (wait_light)
  );

  // det = {front,left,right}; cmd = {back,right,left,forward}; o = {fwd,tl,tr,wait}
  typedef struct {
    logic       r;
    logic [1:0] gs;
    logic [2:0] det;
    logic [3:0] cmd;
    logic [2:0] st;
    logic [3:0] o;
  } vec_t;

  vec_t vecs[19];

  task automatic drive(input logic r, input logic [1:0] gs, input logic [2:0] det,
                       input logic [3:0] cmd);
    rst            = r;
    global_state   = gs;
    front_detector = det[2];
    left_detector  = det[1];
    right_detector = det[0];
    cmd_back       = cmd[3];
    cmd_right      = cmd[2];
    cmd_left       = cmd[1];
    cmd_forward    = cmd[0];
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [3:0] o);
    logic [6:0] got;
    got = {state_code, move_forward_signal, turn_left_signal, turn_right_signal, wait_light};
    checks++;
    if (got !== {st, o}) begin
      errors++;
      $display("FAIL %s: got state=%0d fwd/tl/tr/wait=%b, expected state=%0d fwd/tl/tr/wait=%b",
               name, got[6:4], got[3:0], st, o);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 3'b111, 4'b0000, S_IDLE, NO};
    vecs[1]  = '{1'b0, 2'b00, 3'b111, 4'b0000, S_IDLE, NO};
    vecs[2]  = '{1'b0, 2'b10, 3'b111, 4'b0000, S_WAIT, WL};
    vecs[3]  = '{1'b0, 2'b10, 3'b011, 4'b0011, S_MOVE, MV};
    vecs[4]  = '{1'b0, 2'b10, 3'b001, 4'b0011, S_MOVE, MV};
    vecs[5]  = '{1'b0, 2'b10, 3'b001, 4'b0011, S_MOVE, MV};
    vecs[6]  = '{1'b0, 2'b10, 3'b001, 4'b0011, S_MOVE, MV};
    vecs[7]  = '{1'b0, 2'b10, 3'b001, 4'b0011, S_MOVE, MV};
    vecs[8]  = '{1'b0, 2'b10, 3'b001, 4'b0011, S_MOVE, MV};
    vecs[9]  = '{1'b0, 2'b10, 3'b011, 4'b0011, S_MOVE, MV};
    vecs[10] = '{1'b0, 2'b10, 3'b001, 4'b0011, S_WAIT, WL};
    vecs[11] = '{1'b0, 2'b10, 3'b011, 4'b0011, S_WAIT, WL};
    vecs[12] = '{1'b0, 2'b10, 3'b011, 4'b0000, S_WAIT, WL};
    vecs[13] = '{1'b0, 2'b10, 3'b011, 4'b0100, S_WAIT, WL};
    vecs[14] = '{1'b0, 2'b10, 3'b011, 4'b0000, S_WAIT, WL};
    vecs[15] = '{1'b0, 2'b10, 3'b010, 4'b0100, S_TURN, TR};
    vecs[16] = '{1'b0, 2'b10, 3'b010, 4'b0000, S_TURN, TR};
    vecs[17] = '{1'b1, 2'b10, 3'b010, 4'b0000, S_IDLE, NO};
    vecs[18] = '{1'b0, 2'b10, 3'b111, 4'b0000, S_WAIT, WL};

    drive(1'b1, 2'b00, 3'b111, 4'b0000);
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].r, vecs[i].gs, vecs[i].det, vecs[i].cmd);
      step();
      check($sformatf("vec[%0d]", i), vecs[i].st, vecs[i].o);
    end

    // U-turn from WAIT: eight turn-left cycles, three settle, back to WAIT with front blocked.
    // A left press rises during the turn and is still held when WAIT is re-entered.
    drive(1'b0, 2'b10, 3'b111, 4'b1000);
    step();
    check("uturn[0]", S_TURN, TL);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) drive(1'b0, 2'b10, 3'b101, 4'b0010);
      step();
      check($sformatf("uturn[%0d]", i), S_TURN, TL);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("uturn_settle[%0d]", i), S_SETTLE, NO);
    end
    step();
    check("uturn_to_wait", S_WAIT, WL);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("held_left[%0d]", i), S_WAIT, WL);
    end

    // Left press toward a left wall is ignored.
    drive(1'b0, 2'b10, 3'b111, 4'b0000);
    step();
    check("left_release", S_WAIT, WL);
    drive(1'b0, 2'b10, 3'b111, 4'b0010);
    step();
    check("left_blocked", S_WAIT, WL);
    drive(1'b0, 2'b10, 3'b111, 4'b0000);
    step();
    check("left_blocked_hold", S_WAIT, WL);

    // Forward into a corridor whose right opens immediately: junction only after MOVE_MIN.
    drive(1'b0, 2'b10, 3'b011, 4'b0001);
    step();
    check("auto_move[0]", S_MOVE, MV);
    drive(1'b0, 2'b10, 3'b110, 4'b0000);
    for (int i = 1; i < 6; i++) begin
      step();
      check($sformatf("auto_move[%0d]", i), S_MOVE, MV);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("auto_right[%0d]", i), S_TURN, TR);
    end
    drive(1'b0, 2'b10, 3'b011, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("auto_settle[%0d]", i), S_SETTLE, NO);
    end
    step();
    check("settle_to_move", S_MOVE, MV);

    // Mode drop during MOVE, then re-entry.
    drive(1'b0, 2'b01, 3'b011, 4'b0000);
    step();
    check("mode_drop", S_IDLE, NO);
    drive(1'b0, 2'b10, 3'b011, 4'b0000);
    step();
    check("mode_back", S_WAIT, WL);

    // Dead end reached while moving: automatic U-turn after the arming delay.
    drive(1'b0, 2'b10, 3'b011, 4'b0001);
    step();
    check("dead_end_move", S_MOVE, MV);
    drive(1'b0, 2'b10, 3'b111, 4'b0000);
    for (int i = 0; i < 5; i++) step();
    check("dead_end_armed", S_MOVE, MV);
    step();
    check("dead_end_uturn", S_TURN, TL);
    for (int i = 0; i < 7; i++) step();
    check("dead_end_uturn_last", S_TURN, TL);
    step();
    check("dead_end_settle", S_SETTLE, NO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
